// File: rtl/registrador_if_id.sv
// registrador_if_id
// Pipeline register between instruction fetch and decode.
// A two-entry skid buffer (principal + reserva) accepts fetched words through
// a valid/ready handshake, so fetch never loses a word while decode stalls.
// The head word is presented whole and split into MIPS-style fields.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   entrada_valida/_pronta, instrucao_entrada, pc_entrada : fetch side handshake
//   flush               : synchronous discard of buffered and incoming words
//   saida_valida/_pronta, instrucao_saida, pc_mais4_saida : decode side handshake
//   opcode, rs, rt, rd, shamt, funct, imediato, alvo_salto : slices of instrucao_saida
//   ciclos_parado       : saturating count of decode stall cycles
module registrador_if_id #(
  parameter int unsigned LARGURA_DADOS    = 32'd32,
  parameter int unsigned INCREMENTO_PC    = 32'd4,
  parameter int unsigned LARGURA_CONTADOR = 32'd16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        entrada_valida,
  output logic                        entrada_pronta,
  input  logic [LARGURA_DADOS-1:0]    instrucao_entrada,
  input  logic [LARGURA_DADOS-1:0]    pc_entrada,
  input  logic                        flush,
  output logic                        saida_valida,
  input  logic                        saida_pronta,
  output logic [LARGURA_DADOS-1:0]    instrucao_saida,
  output logic [LARGURA_DADOS-1:0]    pc_mais4_saida,
  output logic [5:0]                  opcode,
  output logic [4:0]                  rs,
  output logic [4:0]                  rt,
  output logic [4:0]                  rd,
  output logic [4:0]                  shamt,
  output logic [5:0]                  funct,
  output logic [15:0]                 imediato,
  output logic [25:0]                 alvo_salto,
  output logic [LARGURA_CONTADOR-1:0] ciclos_parado
);

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    DOIS  = 2'd2
  } estado_t;

  localparam logic [LARGURA_DADOS-1:0]    ZERO_DADOS  = {LARGURA_DADOS{1'b0}};
  localparam logic [LARGURA_CONTADOR-1:0] CONT_MAXIMO = {LARGURA_CONTADOR{1'b1}};
  localparam logic [LARGURA_CONTADOR-1:0] CONT_UM     = {{(LARGURA_CONTADOR-1){1'b0}}, 1'b1};

  estado_t                     estado_r, estado_s;
  logic [LARGURA_DADOS-1:0]    principal_instr_r, principal_instr_s;
  logic [LARGURA_DADOS-1:0]    principal_pc4_r, principal_pc4_s;
  logic [LARGURA_DADOS-1:0]    reserva_instr_r, reserva_instr_s;
  logic [LARGURA_DADOS-1:0]    reserva_pc4_r, reserva_pc4_s;
  logic                        saida_valida_r;
  logic                        entrada_pronta_r;
  logic [LARGURA_CONTADOR-1:0] ciclos_parado_r;
  logic                        push_s;
  logic                        pop_s;
  logic [LARGURA_DADOS-1:0]    pc4_entrada_s;

  assign push_s        = entrada_valida & entrada_pronta_r;
  assign pop_s         = saida_valida_r & saida_pronta;
  // Wraps naturally modulo 2^LARGURA_DADOS.
  assign pc4_entrada_s = pc_entrada + LARGURA_DADOS'(INCREMENTO_PC);

  // Next-state and next-contents of the skid buffer; flush overrides everything.
  always_comb begin
    estado_s          = estado_r;
    principal_instr_s = principal_instr_r;
    principal_pc4_s   = principal_pc4_r;
    reserva_instr_s   = reserva_instr_r;
    reserva_pc4_s     = reserva_pc4_r;
    if (flush) begin
      // The principal entry is zeroed so the outputs read as a NOP while empty.
      estado_s          = VAZIO;
      principal_instr_s = ZERO_DADOS;
      principal_pc4_s   = ZERO_DADOS;
    end else begin
      case (estado_r)
        VAZIO: begin
          if (push_s) begin
            estado_s          = UM;
            principal_instr_s = instrucao_entrada;
            principal_pc4_s   = pc4_entrada_s;
          end else begin
            estado_s = VAZIO;
          end
        end
        UM: begin
          if (push_s && !pop_s) begin
            estado_s        = DOIS;
            reserva_instr_s = instrucao_entrada;
            reserva_pc4_s   = pc4_entrada_s;
          end else if (push_s && pop_s) begin
            estado_s          = UM;
            principal_instr_s = instrucao_entrada;
            principal_pc4_s   = pc4_entrada_s;
          end else if (pop_s) begin
            estado_s          = VAZIO;
            principal_instr_s = ZERO_DADOS;
            principal_pc4_s   = ZERO_DADOS;
          end else begin
            estado_s = UM;
          end
        end
        DOIS: begin
          // entrada_pronta is low here, so no push can arrive.
          if (pop_s) begin
            estado_s          = UM;
            principal_instr_s = reserva_instr_r;
            principal_pc4_s   = reserva_pc4_r;
          end else begin
            estado_s = DOIS;
          end
        end
        default: begin
          estado_s          = VAZIO;
          principal_instr_s = ZERO_DADOS;
          principal_pc4_s   = ZERO_DADOS;
        end
      endcase
    end
  end

  // Buffer state, contents and handshake flags; the flags are registered
  // from the next state so entrada_pronta has no path from saida_pronta.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r          <= VAZIO;
      principal_instr_r <= ZERO_DADOS;
      principal_pc4_r   <= ZERO_DADOS;
      reserva_instr_r   <= ZERO_DADOS;
      reserva_pc4_r     <= ZERO_DADOS;
      saida_valida_r    <= 1'b0;
      entrada_pronta_r  <= 1'b1;
    end else begin
      estado_r          <= estado_s;
      principal_instr_r <= principal_instr_s;
      principal_pc4_r   <= principal_pc4_s;
      reserva_instr_r   <= reserva_instr_s;
      reserva_pc4_r     <= reserva_pc4_s;
      saida_valida_r    <= (estado_s != VAZIO);
      entrada_pronta_r  <= (estado_s != DOIS);
    end
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ciclos_parado_r <= {LARGURA_CONTADOR{1'b0}};
    end else if (saida_valida_r && !saida_pronta && !flush &&
                 (ciclos_parado_r != CONT_MAXIMO)) begin
      ciclos_parado_r <= ciclos_parado_r + CONT_UM;
    end else begin
      ciclos_parado_r <= ciclos_parado_r;
    end
  end

  assign entrada_pronta  = entrada_pronta_r;
  assign saida_valida    = saida_valida_r;
  assign instrucao_saida = principal_instr_r;
  assign pc_mais4_saida  = principal_pc4_r;
  assign ciclos_parado   = ciclos_parado_r;

  assign opcode     = principal_instr_r[31:26];
  assign rs         = principal_instr_r[25:21];
  assign rt         = principal_instr_r[20:16];
  assign rd         = principal_instr_r[15:11];
  assign shamt      = principal_instr_r[10:6];
  assign funct      = principal_instr_r[5:0];
  assign imediato   = principal_instr_r[15:0];
  assign alvo_salto = principal_instr_r[25:0];

endmodule

// File: tb/tb_registrador_if_id.sv
// tb_registrador_if_id
// Self-checking bench for registrador_if_id. Every accepted word is pushed to
// an expected queue with a bench-computed PC+4; the head of the queue is
// compared against the outputs every cycle and popped on each transfer.
module tb_registrador_if_id;

  logic        clk;
  logic        reset;
  logic        entrada_valida;
  logic        entrada_pronta;
  logic [31:0] instrucao_entrada;
  logic [31:0] pc_entrada;
  logic        flush;
  logic        saida_valida;
  logic        saida_pronta;
  logic [31:0] instrucao_saida;
  logic [31:0] pc_mais4_saida;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imediato;
  logic [25:0] alvo_salto;
  logic [15:0] ciclos_parado;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  registrador_if_id dut (
    .clk               (clk),
    .reset             (reset),
    .entrada_valida    (entrada_valida),
    .entrada_pronta    (entrada_pronta),
    .instrucao_entrada (instrucao_entrada),
    .pc_entrada        (pc_entrada),
    .flush             (flush),
    .saida_valida      (saida_valida),
    .saida_pronta      (saida_pronta),
    .instrucao_saida   (instrucao_saida),
    .pc_mais4_saida    (pc_mais4_saida),
    .opcode            (opcode),
    .rs                (rs),
    .rt                (rt),
    .rd                (rd),
    .shamt             (shamt),
    .funct             (funct),
    .imediato          (imediato),
    .alvo_salto        (alvo_salto),
    .ciclos_parado     (ciclos_parado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: compare outputs with the scoreboard head at the falling
  // edge, then record this cycle's transfers, then step past the rising edge.
  task automatic tick();
    logic exp_valid;
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
    end else begin
      exp_valid = (sb_q.size() != 0);
      checks++;
      if (saida_valida !== exp_valid) begin
        failures++;
        $display("FAIL sb_valid: saida_valida=%b expected=%b", saida_valida, exp_valid);
      end
      checks++;
      if (exp_valid) begin
        if ({instrucao_saida, pc_mais4_saida} !== sb_q[0]) begin
          failures++;
          $display("FAIL sb_data: instr/pc4=%h expected=%h", {instrucao_saida, pc_mais4_saida}, sb_q[0]);
        end
      end else if ({instrucao_saida, pc_mais4_saida} !== 64'd0) begin
        failures++;
        $display("FAIL sb_nop: instr/pc4=%h expected=0", {instrucao_saida, pc_mais4_saida});
      end
      if (exp_valid && saida_pronta) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      else if (entrada_valida && entrada_pronta === 1'b1)
        sb_q.push_back({instrucao_entrada, pc_entrada + 32'd4});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    entrada_valida    = 1'b0;
    instrucao_entrada = 32'd0;
    pc_entrada        = 32'd0;
    flush             = 1'b0;
    saida_pronta      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1 || ciclos_parado !== 16'd0 ||
        instrucao_saida !== 32'd0 || pc_mais4_saida !== 32'd0 || alvo_salto !== 26'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b pronta=%b cnt=%h instr=%h pc4=%h expected 0/1/0/0/0",
               saida_valida, entrada_pronta, ciclos_parado, instrucao_saida, pc_mais4_saida);
    end
    // A word offered during reset must not be accepted.
    entrada_valida = 1'b1; instrucao_entrada = 32'h1234_5678; pc_entrada = 32'h0000_0100;
    @(posedge clk); #1;
    checks++;
    if (saida_valida !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_push: saida_valida=%b expected=0", saida_valida);
    end
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    do_reset();
    saida_pronta = 1'b1;
    entrada_valida = 1'b1; instrucao_entrada = 32'h8C22_0010; pc_entrada = 32'h0040_0000;
    tick();
    checks++;
    if (saida_valida !== 1'b1 || opcode !== 6'h23 || rs !== 5'd1 || rt !== 5'd2 ||
        imediato !== 16'h0010 || pc_mais4_saida !== 32'h0040_0004 || entrada_pronta !== 1'b1) begin
      failures++;
      $display("FAIL stream_first: v=%b op=%h rs=%0d rt=%0d imm=%h pc4=%h rdy=%b expected 1/23/1/2/0010/00400004/1",
               saida_valida, opcode, rs, rt, imediato, pc_mais4_saida, entrada_pronta);
    end
    instrucao_entrada = 32'h0085_1020; pc_entrada = 32'h0040_0004;
    tick();
    checks++;
    if (saida_valida !== 1'b1 || funct !== 6'h20 || rd !== 5'd2 || rs !== 5'd4 || rt !== 5'd5 ||
        shamt !== 5'd0 || pc_mais4_saida !== 32'h0040_0008 || entrada_pronta !== 1'b1) begin
      failures++;
      $display("FAIL stream_second: v=%b funct=%h rd=%0d rs=%0d rt=%0d pc4=%h rdy=%b expected 1/20/2/4/5/00400008/1",
               saida_valida, funct, rd, rs, rt, pc_mais4_saida, entrada_pronta);
    end
    entrada_valida = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall_skid();
    do_reset();
    saida_pronta = 1'b0;
    entrada_valida = 1'b1; instrucao_entrada = 32'hAAAA_0001; pc_entrada = 32'h0000_1000;
    tick();
    instrucao_entrada = 32'hBBBB_0002; pc_entrada = 32'h0000_1004;
    tick();
    // Buffer is full; this word must be refused until space frees.
    instrucao_entrada = 32'hCCCC_0003; pc_entrada = 32'h0000_1008;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (entrada_pronta !== 1'b0 || instrucao_saida !== 32'hAAAA_0001) begin
        failures++;
        $display("FAIL skid_full: pronta=%b instr=%h expected 0/aaaa0001", entrada_pronta, instrucao_saida);
      end
      tick();
    end
    entrada_valida = 1'b0;
    saida_pronta = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ciclos_parado !== 16'd4 || saida_valida !== 1'b0 || entrada_pronta !== 1'b1) begin
      failures++;
      $display("FAIL skid_stalls: cnt=%0d valid=%b pronta=%b expected 4/0/1", ciclos_parado, saida_valida, entrada_pronta);
    end
  endtask

  task automatic test_neg_imm();
    do_reset();
    saida_pronta = 1'b1;
    entrada_valida = 1'b1; instrucao_entrada = 32'h2008_FFFF; pc_entrada = 32'h0040_0010;
    tick();
    entrada_valida = 1'b0;
    checks++;
    if (imediato !== 16'hFFFF || rt !== 5'd8 || opcode !== 6'h08 || rs !== 5'd0 ||
        alvo_salto !== 26'h008_FFFF) begin
      failures++;
      $display("FAIL neg_imm: imm=%h rt=%0d op=%h rs=%0d alvo=%h expected ffff/8/08/0/008ffff",
               imediato, rt, opcode, rs, alvo_salto);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    saida_pronta = 1'b0;
    entrada_valida = 1'b1; instrucao_entrada = 32'h1111_1111; pc_entrada = 32'h0000_2000;
    tick();
    instrucao_entrada = 32'h2222_2222; pc_entrada = 32'h0000_2004;
    tick();
    // Flush in DOIS with a same-cycle offer of C and a completed pop of A.
    flush = 1'b1; saida_pronta = 1'b1;
    instrucao_entrada = 32'h3333_3333; pc_entrada = 32'h0000_2008;
    tick();
    flush = 1'b0; entrada_valida = 1'b0;
    checks++;
    if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1 || instrucao_saida !== 32'd0) begin
      failures++;
      $display("FAIL flush_dois: valid=%b pronta=%b instr=%h expected 0/1/0", saida_valida, entrada_pronta, instrucao_saida);
    end
    tick();
    tick();
    // Flush in UM while a push is actually accepted: the pushed word must vanish.
    entrada_valida = 1'b1; saida_pronta = 1'b0; instrucao_entrada = 32'h4444_4444;
    tick();
    flush = 1'b1; instrucao_entrada = 32'h5555_5555;
    tick();
    flush = 1'b0; entrada_valida = 1'b0;
    checks++;
    if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1) begin
      failures++;
      $display("FAIL flush_um: valid=%b pronta=%b expected 0/1", saida_valida, entrada_pronta);
    end
    tick();
    tick();
  endtask

  task automatic test_pc_wrap_and_saturation();
    do_reset();
    saida_pronta = 1'b0;
    entrada_valida = 1'b1; instrucao_entrada = 32'h0800_0040; pc_entrada = 32'hFFFF_FFFC;
    tick();
    entrada_valida = 1'b0;
    checks++;
    if (pc_mais4_saida !== 32'h0000_0000 || saida_valida !== 1'b1) begin
      failures++;
      $display("FAIL pc_wrap: pc4=%h valid=%b expected 00000000/1", pc_mais4_saida, saida_valida);
    end
    for (int i = 0; i < 1000; i++) tick();
    checks++;
    if (ciclos_parado !== 16'd1000) begin
      failures++;
      $display("FAIL cnt_mid: cnt=%0d expected=1000", ciclos_parado);
    end
    for (int i = 0; i < 69000; i++) tick();
    checks++;
    if (ciclos_parado !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_sat: cnt=%h expected=ffff", ciclos_parado);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ciclos_parado !== 16'hFFFF || instrucao_saida !== 32'h0800_0040) begin
      failures++;
      $display("FAIL cnt_hold: cnt=%h instr=%h expected ffff/08000040", ciclos_parado, instrucao_saida);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    saida_pronta = 1'b0;
    entrada_valida = 1'b1; instrucao_entrada = 32'h6666_6666; pc_entrada = 32'h0000_3000;
    tick();
    instrucao_entrada = 32'h7777_7777; pc_entrada = 32'h0000_3004;
    tick();
    tick();
    checks++;
    if (entrada_pronta !== 1'b0 || ciclos_parado === 16'd0) begin
      failures++;
      $display("FAIL areset_pre: pronta=%b cnt=%0d expected 0/nonzero", entrada_pronta, ciclos_parado);
    end
    // Assert reset between edges; the effect must be visible before any edge.
    #1 reset = 1'b1;
    #1;
    checks++;
    if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1 || ciclos_parado !== 16'd0 ||
        instrucao_saida !== 32'd0 || pc_mais4_saida !== 32'd0) begin
      failures++;
      $display("FAIL areset_now: valid=%b pronta=%b cnt=%0d instr=%h pc4=%h expected 0/1/0/0/0",
               saida_valida, entrada_pronta, ciclos_parado, instrucao_saida, pc_mais4_saida);
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    sb_q.delete();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall_skid();
    test_neg_imm();
    test_flush();
    test_async_reset();
    test_pc_wrap_and_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/registrador_if_id.md
Name: registrador_if_id

Overview:
Pipeline register between instruction fetch and decode. Accepts fetched instruction and PC through a valid/ready handshake and buffers up to two instructions in a skid buffer, so fetch never loses a word when decode stalls. Presents the instruction split into fields. The 16-bit immediate field is the direct input of the 16->32 sign-extension stage. Supports synchronous flush for branches/jumps and counts decode stall cycles.

Parameters:
LARGURA_DADOS, 32, width of instruction, PC and PC+4 buses
INCREMENTO_PC, 4, constant added to the incoming PC
LARGURA_CONTADOR, 16, width of the stall counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
entrada_valida  input  1  fetch offers instrucao_entrada/pc_entrada
entrada_pronta  output  1  block can accept this cycle
instrucao_entrada  input  LARGURA_DADOS  fetched instruction word
pc_entrada  input  LARGURA_DADOS  PC of fetched instruction
flush  input  1  discard all buffered and incoming instructions
saida_valida  output  1  output fields hold a valid instruction
saida_pronta  input  1  decode consumes this cycle
instrucao_saida  output  LARGURA_DADOS  head instruction
pc_mais4_saida  output  LARGURA_DADOS  head PC + INCREMENTO_PC
opcode  output  6  instrucao_saida[31:26]
rs  output  5  [25:21]
rt  output  5  [20:16]
rd  output  5  [15:11]
shamt  output  5  [10:6]
funct  output  6  [5:0]
imediato  output  16  [15:0], feeds the sign extender
alvo_salto  output  26  [25:0]
ciclos_parado  output  LARGURA_CONTADOR  saturating stall counter

Behaviour:
- Reset is asynchronous, active-high. While reset is high: saida_valida=0, instrucao_saida=0, pc_mais4_saida=0, all fields=0, ciclos_parado=0, both buffer entries invalid, entrada_pronta=1. No transfer is accepted while reset is high.
- Storage has two entries: principal (drives the outputs) and reserva (skid). entrada_pronta = !reserva_valida, derived from a register with no combinational path from saida_pronta.
- Push = entrada_valida & entrada_pronta. Pop = saida_valida & saida_pronta.
- State encoding: VAZIO, UM (principal only), DOIS (principal + reserva). Transitions per edge:
  - VAZIO: push -> UM.
  - UM: push & !pop -> DOIS (new word to reserva). push & pop -> UM (new word to principal). pop & !push -> VAZIO.
  - DOIS: pop -> UM (reserva moves to principal). No push is possible in DOIS.
- Latency: a word pushed at edge N appears on the outputs after edge N, so saida_valida=1 in cycle N+1. Order is strictly FIFO.
- pc_mais4_saida = pc + INCREMENTO_PC modulo 2^LARGURA_DADOS, computed at push and stored. 0xFFFFFFFC wraps to 0x00000000.
- Fields are combinational slices of instrucao_saida. When saida_valida=0, instrucao_saida and pc_mais4_saida are forced to 0, so every field reads 0 (a NOP).
- Flush is synchronous and has priority over push and pop. At the edge: both entries are invalidated and any same-cycle push is discarded. Next cycle: saida_valida=0, entrada_pronta=1. A pop in the flush cycle is still a completed transfer for decode.
- ciclos_parado increments by 1 each cycle with saida_valida & !saida_pronta & !flush. It saturates at all-ones and is cleared only by reset.
- Outputs are stable while saida_valida=1 and saida_pronta=0.

Test Plan:
- Reset mid-stream with DOIS occupied: assert reset asynchronously between edges -> saida_valida=0, entrada_pronta=1, ciclos_parado=0 immediately, without waiting for an edge.
- Stream at full rate with saida_pronta=1: push 0x8C220010 @pc 0x00400000, then 0x00851020 @0x00400004 -> one-cycle latency. First output: opcode=0x23, rs=1, rt=2, imediato=0x0010, pc_mais4_saida=0x00400004. Second output: funct=0x20, rd=2. entrada_pronta stays 1.
- Stall with skid: saida_pronta=0 and push A, B -> DOIS, entrada_pronta=0, A held stable. Release saida_pronta -> A, then B, in order; ciclos_parado equals the number of stalled cycles.
- Negative immediate: push 0x2008FFFF -> imediato=0xFFFF, rt=8, opcode=0x08.
- Flush in DOIS with simultaneous push of C -> next cycle saida_valida=0, C never appears, entrada_pronta=1.
- PC wrap and counter saturation: pc_entrada=0xFFFFFFFC -> pc_mais4_saida=0x00000000. Hold a stall for 70000 cycles -> ciclos_parado=0xFFFF and stays there.
